sa_tile_sequencer: RTL and testbench
====================================

Name: sa_tile_sequencer

Overview:
Sequences one output tile through the systolic array wrapper. It accepts a tile job (operand base address and K beat count) over a valid/ready handshake, then issues operand-buffer reads and drives the array's ctrl/last/clear/enable strobes. It waits out the array's skew latency, then hands the N result rows to the writeback stage one row per handshake. It sits between the job dispatcher and systolic_array_wrap plus its operand buffers.

Parameters:
N, 4, systolic array dimension; must equal SYS_ARRAY_SIZE.
K_W, 8, width of the K beat-count field.
ADDR_W, 8, operand buffer address width.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
job_valid_i  in  1  job request
job_ready_o  out  1  sequencer can accept a job
job_k_i  in  K_W  number of operand beats K
job_base_i  in  ADDR_W  first operand buffer address
rd_en_o  out  1  operand buffer read strobe; data returns next cycle
rd_addr_o  out  ADDR_W  operand buffer read address
array_en_o  out  1  operand beat presented to the array this cycle
array_clr_o  out  1  first beat of a tile; array accumulators restart
array_ctrl_o  out  1  array phase control, drives ctrl_i
array_last_o  out  1  final operand beat, drives last_i
res_valid_o  out  1  result row available
res_ready_i  in  1  writeback accepts the row
res_row_o  out  $clog2(N)  index of the result row offered
done_o  out  1  one-cycle pulse when the tile is complete

Behaviour:
- Reset (asynchronous, any state): state=IDLE. All outputs are 0 except job_ready_o=1. Counters and the address register are 0. An in-flight tile is abandoned and no done_o is issued.
- States: IDLE, FEED, FLUSH, RESULT.
- IDLE:
  - job_ready_o=1. On job_valid_i&job_ready_o, latch K and base.
  - Next state is FEED if K!=0, otherwise RESULT.
- FEED:
  - Lasts exactly K cycles, with rd_en_o=1 every cycle.
  - rd_addr_o = base, base+1, …, base+K-1, wrapping modulo 2^ADDR_W.
  - After the K-th read, go to FLUSH.
- Beat pipeline:
  - array_en_o is rd_en_o delayed by 1 cycle, aligned with the buffer read data.
  - array_clr_o=1 only with the first array_en_o beat.
  - array_last_o=1 only with the K-th beat; for K=1, clr and last are asserted together.
- FLUSH:
  - Lasts 2N-1 cycles. The first FLUSH cycle is the one carrying the last beat.
  - Then go to RESULT.
- array_ctrl_o:
  - Toggles every cycle from the first array_en_o cycle through the final FLUSH cycle.
  - Held at 0 in IDLE and RESULT; the first toggle drives it to 1.
- RESULT:
  - res_valid_o=1 with res_row_o=r, for r = 0..N-1.
  - r advances only on res_valid_o&res_ready_i; res_row_o is stable while stalled.
  - After row N-1 is accepted, go to IDLE with done_o=1 in that IDLE cycle. A new job may be accepted in that same cycle.
- K=0: no reads and no array strobes. RESULT runs normally and rows reflect the array's current (cleared or stale) contents; the caller must not rely on them.
- job_valid_i outside IDLE is ignored (job_ready_o=0). Job inputs are sampled only on the accept edge.
- res_ready_i outside RESULT is ignored.

Test Plan:
- N=4, accept job K=4, base=0x10 at cycle 0:
  - rd_en_o and rd_addr_o=0x10..0x13 in cycles 1–4.
  - array_en_o in cycles 2–5, array_clr_o in cycle 2, array_last_o in cycle 5.
  - array_ctrl_o toggles in cycles 2–11.
  - res_valid_o rises in cycle 12 with res_row_o=0. With res_ready_i=1, rows 0..3 are offered in cycles 12–15 and done_o pulses in cycle 16.
- K=1, base=0x00: single read in cycle 1; array_clr_o and array_last_o are both high in cycle 2; RESULT starts in cycle 9.
- Address wrap, K=3, base=0xFE: rd_addr_o = 0xFE, 0xFF, 0x00.
- Result backpressure: hold res_ready_i=0 for 3 cycles on row 2 → res_row_o stays 2 and res_valid_o stays 1; done_o is delayed by exactly 3 cycles.
- job_valid_i held high throughout: the second job is accepted only in the done_o cycle. K=0 job: no rd_en_o or array_en_o, res_valid_o on the cycle after accept.
- Assert rst_i in FEED cycle 2, between clock edges → all outputs go to their reset values immediately, job_ready_o=1, and no done_o afterwards.

Source files
------------

// File: rtl/sa_tile_sequencer.sv
// Tile sequencer for the systolic array: accepts a tile job, streams K operand
// reads with array strobes, waits out the array skew, then hands off N result rows.
module sa_tile_sequencer #(
    parameter int N      = 4,
    parameter int K_W    = 8,
    parameter int ADDR_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 job_valid_i,
    output logic                 job_ready_o,
    input  logic [K_W-1:0]       job_k_i,
    input  logic [ADDR_W-1:0]    job_base_i,
    output logic                 rd_en_o,
    output logic [ADDR_W-1:0]    rd_addr_o,
    output logic                 array_en_o,
    output logic                 array_clr_o,
    output logic                 array_ctrl_o,
    output logic                 array_last_o,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [$clog2(N)-1:0] res_row_o,
    output logic                 done_o
);

    localparam int ROW_W = $clog2(N);
    localparam int FL_W  = $clog2(2 * N);
    localparam int CNT_W = (K_W > FL_W) ? K_W : FL_W;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        FLUSH,
        RESULT
    } state_t;

    state_t             state_q, state_d;
    logic [K_W-1:0]     k_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ROW_W-1:0]   row_q;
    logic               en_q, clr_q, last_q, tog_q, done_q;

    logic feed_last, flush_last, row_last, res_fire, window;

    assign feed_last  = (state_q == FEED)  && (cnt_q == CNT_W'(k_q) - CNT_W'(1));
    assign flush_last = (state_q == FLUSH) && (cnt_q == CNT_W'(2 * N - 2));
    assign row_last   = (row_q == ROW_W'(N - 1));
    assign res_fire   = (state_q == RESULT) && res_ready_i;

    // ctrl toggles from the first presented beat until the end of the skew flush.
    assign window = ((state_q == FEED) && en_q) || (state_q == FLUSH);

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (job_valid_i) state_d = (job_k_i != '0) ? FEED : RESULT;
            FEED:    if (feed_last) state_d = FLUSH;
            FLUSH:   if (flush_last) state_d = RESULT;
            RESULT:  if (res_ready_i && row_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            k_q     <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            row_q   <= '0;
            en_q    <= 1'b0;
            clr_q   <= 1'b0;
            last_q  <= 1'b0;
            tog_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;

            if (state_q == IDLE && job_valid_i) begin
                k_q    <= job_k_i;
                addr_q <= job_base_i;
            end else if (state_q == FEED) begin
                addr_q <= addr_q + ADDR_W'(1);
            end

            // One counter serves both the beat count and the flush count.
            if (state_d != state_q)
                cnt_q <= '0;
            else if (state_q == FEED || state_q == FLUSH)
                cnt_q <= cnt_q + CNT_W'(1);

            if (res_fire)
                row_q <= row_last ? '0 : row_q + ROW_W'(1);

            en_q   <= (state_q == FEED);
            clr_q  <= (state_q == FEED) && (cnt_q == '0);
            last_q <= feed_last;
            tog_q  <= window ? ~tog_q : 1'b0;
            done_q <= res_fire && row_last;
        end
    end

    assign job_ready_o  = (state_q == IDLE);
    assign rd_en_o      = (state_q == FEED);
    assign rd_addr_o    = addr_q;
    assign array_en_o   = en_q;
    assign array_clr_o  = clr_q;
    assign array_last_o = last_q;
    assign array_ctrl_o = window && !tog_q;
    assign res_valid_o  = (state_q == RESULT);
    assign res_row_o    = row_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_sa_tile_sequencer.sv
// Self-checking bench for sa_tile_sequencer: directed scenarios plus random jobs,
// compared every cycle against a timeline model built from per-job cycle offsets.
module tb_sa_tile_sequencer;

    localparam int N      = 4;
    localparam int K_W    = 8;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              job_valid;
    logic              job_ready;
    logic [K_W-1:0]    job_k;
    logic [ADDR_W-1:0] job_base;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              array_en, array_clr, array_ctrl, array_last;
    logic              res_valid, res_ready;
    logic [1:0]        res_row;
    logic              done;

    sa_tile_sequencer #(.N(N), .K_W(K_W), .ADDR_W(ADDR_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .job_valid_i (job_valid),
        .job_ready_o (job_ready),
        .job_k_i     (job_k),
        .job_base_i  (job_base),
        .rd_en_o     (rd_en),
        .rd_addr_o   (rd_addr),
        .array_en_o  (array_en),
        .array_clr_o (array_clr),
        .array_ctrl_o(array_ctrl),
        .array_last_o(array_last),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_row_o   (res_row),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: a job is described by its accept cycle offset t, K and base.
    bit m_busy, m_res, m_done;
    int m_t, m_k, m_base, m_row;
    int cyc, acc_cyc, done_cyc, prev_done_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int res_start(input int k);
        return (k > 0) ? k + 2 * N : 1;
    endfunction

    task automatic check_outputs();
        bit feeding;
        bit e_rd, e_en, e_ctrl;
        feeding = m_busy && !m_res && (m_k > 0);
        e_rd    = feeding && m_t >= 1 && m_t <= m_k;
        e_en    = feeding && m_t >= 2 && m_t <= m_k + 1;
        e_ctrl  = feeding && m_t >= 2 && m_t <= m_k + 2 * N - 1 && ((m_t - 2) % 2 == 0);
        check("job_ready", job_ready, !m_busy);
        check("rd_en", rd_en, e_rd);
        if (e_rd) check("rd_addr", rd_addr, (m_base + m_t - 1) & 255);
        check("array_en", array_en, e_en);
        check("array_clr", array_clr, e_en && m_t == 2);
        check("array_last", array_last, e_en && m_t == m_k + 1);
        check("array_ctrl", array_ctrl, e_ctrl);
        check("res_valid", res_valid, m_res);
        if (m_res) check("res_row", res_row, m_row);
        check("done", done, m_done);
        if (done === 1'b1) done_cyc = cyc;
    endtask

    task automatic model_edge();
        bit next_done = 0;
        if (!m_busy) begin
            if (job_valid) begin
                m_busy  = 1;
                m_res   = 0;
                m_k     = int'(job_k);
                m_base  = int'(job_base);
                m_t     = 1;
                acc_cyc = cyc;
                if (m_t == res_start(m_k)) begin m_res = 1; m_row = 0; end
            end
        end else if (m_res) begin
            if (res_ready) begin
                if (m_row == N - 1) begin
                    m_busy = 0; m_res = 0; next_done = 1;
                end else begin
                    m_row++;
                end
            end
        end else begin
            m_t++;
            if (m_t == res_start(m_k)) begin m_res = 1; m_row = 0; end
        end
        m_done = next_done;
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        m_busy = 0; m_res = 0; m_done = 0; m_t = 0; m_k = 0; m_base = 0; m_row = 0;
    endtask

    task automatic check_reset_values();
        check_outputs();
        check("rst_rd_addr", rd_addr, 0);
        check("rst_res_row", res_row, 0);
    endtask

    // Runs until the model is idle with no pending done; random inputs while busy.
    task automatic run_until_idle(input string tag, input int budget, input bit rnd);
        int n = 0;
        while ((m_busy || m_done) && n < budget) begin
            if (rnd) begin
                res_ready = ($urandom_range(0, 9) < 7);
                job_valid = ($urandom_range(0, 3) == 0);
                job_k     = K_W'($urandom_range(0, 6));
                job_base  = ADDR_W'($urandom);
            end
            tick();
            n++;
        end
        if (n >= budget) check({tag, "_timeout"}, n, 0);
        job_valid = 0;
    endtask

    task automatic start_job(input int k, input int base);
        job_valid = 1;
        job_k     = K_W'(k);
        job_base  = ADDR_W'(base);
        tick();
        job_valid = 0;
        job_k     = '0;
        job_base  = '0;
    endtask

    initial begin
        int stall;
        int k_r, b_r, gap;
        model_reset();
        cyc = 0; done_cyc = -1; prev_done_cyc = -1;
        rst = 1; job_valid = 0; job_k = '0; job_base = '0; res_ready = 0;
        repeat (2) @(negedge clk);
        check_reset_values();
        rst = 0;
        @(posedge clk);
        #1;

        // K=4, base 0x10, writeback always ready: done 16 cycles after accept.
        res_ready = 1;
        start_job(4, 'h10);
        run_until_idle("k4", 60, 0);
        tick();
        check("k4_done_offset", done_cyc - acc_cyc, 16);

        // K=1: clr and last together, RESULT at offset 9, done at 13.
        start_job(1, 'h00);
        run_until_idle("k1", 60, 0);
        tick();
        check("k1_done_offset", done_cyc - acc_cyc, 13);

        // Address wrap past 0xFF.
        start_job(3, 'hFE);
        run_until_idle("wrap", 60, 0);
        tick();
        check("wrap_done_offset", done_cyc - acc_cyc, 15);

        // Backpressure: three stalled cycles on row 2 delay done by exactly 3.
        start_job(2, 'h40);
        stall = 0;
        for (int i = 0; i < 60 && (m_busy || m_done); i++) begin
            res_ready = !(m_res && m_row == 2 && stall < 3);
            if (m_res && m_row == 2 && stall < 3) stall++;
            tick();
        end
        res_ready = 1;
        tick();
        check("bp_done_offset", done_cyc - acc_cyc, 2 + 2 * N + N + 3);

        // job_valid held high: the follow-up K=0 job is taken in the done cycle.
        job_valid = 1; job_k = 8'd2; job_base = 8'h80;
        tick();
        job_k = 8'd0; job_base = 8'h33;
        for (int i = 0; i < 60 && !(m_done === 1'b1 && !m_busy); i++) tick();
        prev_done_cyc = cyc;
        tick();
        check("hold_accept_in_done_cycle", acc_cyc, prev_done_cyc);
        check("hold_second_k", m_k, 0);
        job_valid = 0;
        run_until_idle("k0", 20, 0);
        tick();
        check("k0_done_offset", done_cyc - acc_cyc, 1 + N);

        // Asynchronous reset in the middle of FEED: outputs clear before any edge.
        start_job(5, 'h20);
        tick();
        #2;
        rst = 1;
        #1;
        model_reset();
        check_reset_values();
        @(negedge clk);
        check_reset_values();
        rst = 0;
        @(posedge clk);
        #1;
        done_cyc = -1;
        repeat (20) tick();
        check("no_done_after_reset", done_cyc, -1);

        // Random jobs with random backpressure and ignored job traffic while busy.
        for (int j = 0; j < 30; j++) begin
            gap = $urandom_range(0, 2);
            job_valid = 0;
            repeat (gap) tick();
            k_r = ($urandom_range(0, 3) == 0) ? $urandom_range(9, 20) : $urandom_range(0, 6);
            b_r = $urandom_range(0, 255);
            start_job(k_r, b_r);
            run_until_idle("rand", 300, 1);
        end
        res_ready = 0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
